sdram_fifo_ctrl: RTL and testbench



---
 rtl/sdram_pkg.sv | 24 ++
 rtl/sdram_burst_addr.sv | 42 ++++
 rtl/sdram_fifo_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_sdram_fifo_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM FIFO burst scheduler.
//   - sdram_state_e : scheduler FSM state encoding
//   - Def*          : default widths and burst/threshold constants
//   - cnt_width()   : width of a counter that must hold 0..burst
package sdram_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWr    = 2'd1,
    StRd    = 2'd2,
    StFlush = 2'd3
  } sdram_state_e;

  localparam int unsigned DefAddrW    = 24;
  localparam int unsigned DefNumW     = 10;
  localparam int unsigned DefBurstLen = 256;
  localparam int unsigned DefRdThresh = 512;

  // Holds values 0..burst inclusive.
  function automatic int unsigned cnt_width(input int unsigned burst);
    return $clog2(burst) + 1;
  endfunction

endpackage

// File: rtl/sdram_burst_addr.sv
// Wrapping burst start-address counter.
//   clk, rst_n : clock, asynchronous active-low reset (resets to BASE)
//   adv_i      : burst finished; step by STEP, wrap to BASE on reaching END_ADDR
//   load_i     : restart region at BASE (takes priority over adv_i)
//   addr_o     : current burst start address
module sdram_burst_addr #(
  parameter int unsigned       ADDR_W   = 24,
  parameter logic [ADDR_W-1:0] BASE     = '0,
  parameter logic [ADDR_W-1:0] END_ADDR = ADDR_W'(32'h0004_0000),
  parameter logic [ADDR_W-1:0] STEP     = ADDR_W'(32'h0000_0100)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              adv_i,
  input  logic              load_i,
  output logic [ADDR_W-1:0] addr_o
);

  logic [ADDR_W-1:0] addr_q, addr_d, addr_nxt;

  assign addr_nxt = addr_q + STEP;

  always_comb begin
    addr_d = addr_q;
    if (load_i) begin
      addr_d = BASE;
    end else if (adv_i) begin
      addr_d = (addr_nxt == END_ADDR) ? BASE : addr_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= BASE;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/sdram_fifo_ctrl.sv
// Burst scheduler between the write/read FIFO pair and the SDRAM command controller.
// Issues fixed-length write/read burst requests with wrapping addresses, arbitrates
// round-robin when both directions are pending, and sequences FIFO flushes.
// Ports:
//   clk, rst_n                    : SDRAM-domain clock, async active-low reset
//   wr_fifo_num, rd_fifo_num      : FIFO fill levels
//   rd_en                         : level, enables read bursts
//   wr_load, rd_load              : pulses, restart region and flush FIFO
//   sdram_wr_req/addr, _wr_ack    : write burst handshake (one ack per word)
//   sdram_rd_req/addr, _rd_ack    : read burst handshake (one ack per word)
//   fifo_wr_rst, fifo_rd_rst      : FIFO flushes, 2 cycles
//   busy                          : FSM not idle
// Build option: define SDRAM_PINGPONG_EN to split each region into two banks, the
// reader following the bank the writer is not filling.
module sdram_fifo_ctrl
  import sdram_pkg::*;
#(
  parameter int unsigned       ADDR_W    = DefAddrW,
  parameter int unsigned       NUM_W     = DefNumW,
  parameter int unsigned       BURST_LEN = DefBurstLen,
  parameter logic [ADDR_W-1:0] WR_BASE   = '0,
  parameter logic [ADDR_W-1:0] WR_END    = ADDR_W'(32'h0004_0000),
  parameter logic [ADDR_W-1:0] RD_BASE   = '0,
  parameter logic [ADDR_W-1:0] RD_END    = ADDR_W'(32'h0004_0000),
  parameter int unsigned       RD_THRESH = DefRdThresh
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_W-1:0]  wr_fifo_num,
  input  logic [NUM_W-1:0]  rd_fifo_num,
  input  logic              rd_en,
  input  logic              wr_load,
  input  logic              rd_load,
  output logic              sdram_wr_req,
  output logic [ADDR_W-1:0] sdram_wr_addr,
  input  logic              sdram_wr_ack,
  output logic              sdram_rd_req,
  output logic [ADDR_W-1:0] sdram_rd_addr,
  input  logic              sdram_rd_ack,
  output logic              fifo_wr_rst,
  output logic              fifo_rd_rst,
  output logic              busy
);

  localparam int unsigned       CntW      = cnt_width(BURST_LEN);
  localparam logic [CntW-1:0]   LastCnt   = CntW'(BURST_LEN - 1);
  localparam logic [NUM_W-1:0]  BurstNum  = NUM_W'(BURST_LEN);
  localparam logic [NUM_W-1:0]  ThreshNum = NUM_W'(RD_THRESH);
  localparam logic [ADDR_W-1:0] Step      = ADDR_W'(BURST_LEN);

  sdram_state_e    state_q, state_d;
  logic            prio_q, prio_d;          // 0: write wins next tie, 1: read wins
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            flush_cnt_q, flush_cnt_d;
  logic            wr_flag_q, wr_flag_d;    // sticky load requests
  logic            rd_flag_q, rd_flag_d;
  logic            wr_act_q, wr_act_d;      // which FIFOs the current FLUSH serves
  logic            rd_act_q, rd_act_d;
  logic            wr_adv, rd_adv, wr_reload, rd_reload;
  logic            wr_pend, rd_pend;

  assign wr_pend = (wr_fifo_num >= BurstNum);
  assign rd_pend = rd_en && (rd_fifo_num < ThreshNum);

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    cnt_d       = cnt_q;
    flush_cnt_d = flush_cnt_q;
    wr_flag_d   = wr_flag_q | wr_load;
    rd_flag_d   = rd_flag_q | rd_load;
    wr_act_d    = wr_act_q;
    rd_act_d    = rd_act_q;
    wr_adv      = 1'b0;
    rd_adv      = 1'b0;
    wr_reload   = 1'b0;
    rd_reload   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (wr_flag_q || rd_flag_q || wr_load || rd_load) begin
          // Latch the flush targets so loads arriving during FLUSH queue for the next one.
          state_d     = StFlush;
          flush_cnt_d = 1'b0;
          wr_act_d    = wr_flag_q | wr_load;
          rd_act_d    = rd_flag_q | rd_load;
          wr_flag_d   = 1'b0;
          rd_flag_d   = 1'b0;
        end else if (wr_pend && rd_pend) begin
          state_d = prio_q ? StRd : StWr;
          prio_d  = ~prio_q;
        end else if (wr_pend) begin
          state_d = StWr;
        end else if (rd_pend) begin
          state_d = StRd;
        end
      end
      StWr: begin
        if (sdram_wr_ack) begin
          if (cnt_q == LastCnt) begin
            cnt_d   = '0;
            wr_adv  = 1'b1;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StRd: begin
        if (sdram_rd_ack) begin
          if (cnt_q == LastCnt) begin
            cnt_d   = '0;
            rd_adv  = 1'b1;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StFlush: begin
        if (flush_cnt_q) begin
          state_d   = StIdle;
          wr_reload = wr_act_q;
          rd_reload = rd_act_q;
          wr_act_d  = 1'b0;
          rd_act_d  = 1'b0;
        end else begin
          flush_cnt_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      prio_q      <= 1'b0;
      cnt_q       <= '0;
      flush_cnt_q <= 1'b0;
      wr_flag_q   <= 1'b0;
      rd_flag_q   <= 1'b0;
      wr_act_q    <= 1'b0;
      rd_act_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      cnt_q       <= cnt_d;
      flush_cnt_q <= flush_cnt_d;
      wr_flag_q   <= wr_flag_d;
      rd_flag_q   <= rd_flag_d;
      wr_act_q    <= wr_act_d;
      rd_act_q    <= rd_act_d;
    end
  end

  sdram_burst_addr #(
    .ADDR_W  (ADDR_W),
    .BASE    (WR_BASE),
    .END_ADDR(WR_END),
    .STEP    (Step)
  ) u_wr_addr (
    .clk   (clk),
    .rst_n (rst_n),
    .adv_i (wr_adv),
    .load_i(wr_reload),
    .addr_o(sdram_wr_addr)
  );

`ifdef SDRAM_PINGPONG_EN
  localparam logic [ADDR_W-1:0] RdHalf   = (RD_END - RD_BASE) >> 1;
  localparam logic [ADDR_W-1:0] WrHalfEn = WR_BASE + ((WR_END - WR_BASE) >> 1);

  logic [ADDR_W-1:0] rd_off;
  logic              wr_bank, wr_done_q, wr_done_d, rd_bank_q, rd_bank_d;

  assign wr_bank = (sdram_wr_addr >= WrHalfEn);

  // Reader walks offsets inside one half; the bank is chosen on each half wrap.
  sdram_burst_addr #(
    .ADDR_W  (ADDR_W),
    .BASE    ('0),
    .END_ADDR(RdHalf),
    .STEP    (Step)
  ) u_rd_addr (
    .clk   (clk),
    .rst_n (rst_n),
    .adv_i (rd_adv),
    .load_i(rd_reload),
    .addr_o(rd_off)
  );

  always_comb begin
    wr_done_d = wr_done_q;
    rd_bank_d = rd_bank_q;
    // Writer finished a bank when its burst crosses the midpoint or wraps the region.
    if (wr_adv && ((sdram_wr_addr + Step == WrHalfEn) || (sdram_wr_addr + Step == WR_END))) begin
      wr_done_d = 1'b1;
    end
    if (rd_reload) begin
      rd_bank_d = 1'b0;
    end else if (rd_adv && (rd_off + Step == RdHalf) && wr_done_q) begin
      rd_bank_d = ~wr_bank;
      wr_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_done_q <= 1'b0;
      rd_bank_q <= 1'b0;
    end else begin
      wr_done_q <= wr_done_d;
      rd_bank_q <= rd_bank_d;
    end
  end

  assign sdram_rd_addr = RD_BASE + (rd_bank_q ? RdHalf : '0) + rd_off;
`else
  sdram_burst_addr #(
    .ADDR_W  (ADDR_W),
    .BASE    (RD_BASE),
    .END_ADDR(RD_END),
    .STEP    (Step)
  ) u_rd_addr (
    .clk   (clk),
    .rst_n (rst_n),
    .adv_i (rd_adv),
    .load_i(rd_reload),
    .addr_o(sdram_rd_addr)
  );
`endif

  assign sdram_wr_req = (state_q == StWr);
  assign sdram_rd_req = (state_q == StRd);
  assign fifo_wr_rst  = (state_q == StFlush) && wr_act_q;
  assign fifo_rd_rst  = (state_q == StFlush) && rd_act_q;
  assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_sdram_fifo_ctrl.sv
// Self-checking bench for sdram_fifo_ctrl. Small address regions keep wrap tests short.
module tb_sdram_fifo_ctrl;

  localparam int unsigned BL = 256;
  localparam int unsigned TH = 512;
  localparam logic [23:0] WB = 24'h000000;
  localparam logic [23:0] WE = 24'h000400;
  localparam logic [23:0] RB = 24'h000100;
  localparam logic [23:0] RE = 24'h000400;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [9:0]  wr_fifo_num = '0;
  logic [9:0]  rd_fifo_num = '0;
  logic        rd_en = 1'b0;
  logic        wr_load = 1'b0;
  logic        rd_load = 1'b0;
  logic        sdram_wr_req, sdram_rd_req;
  logic [23:0] sdram_wr_addr, sdram_rd_addr;
  logic        sdram_wr_ack = 1'b0;
  logic        sdram_rd_ack = 1'b0;
  logic        fifo_wr_rst, fifo_rd_rst, busy;

  int checks = 0;
  int errors = 0;

  // Reference model: bursts completed since base per direction, and tie-break owner.
  int unsigned wr_n = 0;
  int unsigned rd_n = 0;
  bit          prio_wr = 1'b1;

  always #5 clk = ~clk;

  sdram_fifo_ctrl #(
    .ADDR_W   (24),
    .NUM_W    (10),
    .BURST_LEN(BL),
    .WR_BASE  (WB),
    .WR_END   (WE),
    .RD_BASE  (RB),
    .RD_END   (RE),
    .RD_THRESH(TH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_fifo_num  (wr_fifo_num),
    .rd_fifo_num  (rd_fifo_num),
    .rd_en        (rd_en),
    .wr_load      (wr_load),
    .rd_load      (rd_load),
    .sdram_wr_req (sdram_wr_req),
    .sdram_wr_addr(sdram_wr_addr),
    .sdram_wr_ack (sdram_wr_ack),
    .sdram_rd_req (sdram_rd_req),
    .sdram_rd_addr(sdram_rd_addr),
    .sdram_rd_ack (sdram_rd_ack),
    .fifo_wr_rst  (fifo_wr_rst),
    .fifo_rd_rst  (fifo_rd_rst),
    .busy         (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_wr_addr();
    return 32'(WB) + (wr_n * BL) % 32'(WE - WB);
  endfunction

  function automatic logic [31:0] exp_rd_addr();
    return 32'(RB) + (rd_n * BL) % 32'(RE - RB);
  endfunction

  // Which direction the scheduler must pick from the current inputs: 0 none, 1 wr, 2 rd.
  task automatic expected_dir(output int d);
    bit wp, rp;
    wp = (int'(wr_fifo_num) >= int'(BL));
    rp = rd_en && (int'(rd_fifo_num) < int'(TH));
    d  = 0;
    if (wp && rp) begin
      d       = prio_wr ? 1 : 2;
      prio_wr = !prio_wr;
    end else if (wp) begin
      d = 1;
    end else if (rp) begin
      d = 2;
    end
  endtask

  function automatic bit burst_ok(input bit is_wr, input logic [31:0] a);
    if (is_wr) return sdram_wr_req === 1'b1 && sdram_rd_req === 1'b0 &&
                      32'(sdram_wr_addr) === a && busy === 1'b1;
    return sdram_rd_req === 1'b1 && sdram_wr_req === 1'b0 &&
           32'(sdram_rd_addr) === a && busy === 1'b1;
  endfunction

  // Runs one burst already requested; optional load pulse, reset, or rd_en drop at an ack index.
  task automatic run_burst(input bit is_wr, input int load_at, input int rst_at,
                           input int drop_at);
    logic [31:0] exp_addr;
    bit held;
    exp_addr = is_wr ? exp_wr_addr() : exp_rd_addr();
    chk(is_wr ? "wr_req_on" : "rd_req_on", is_wr ? sdram_wr_req : sdram_rd_req, 1);
    chk("other_req_off", is_wr ? sdram_rd_req : sdram_wr_req, 0);
    chk(is_wr ? "wr_burst_addr" : "rd_burst_addr",
        is_wr ? sdram_wr_addr : sdram_rd_addr, exp_addr);
    held = 1'b1;
    for (int i = 0; i < int'(BL); i++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        // Acks on the idle direction must be ignored.
        if ($urandom_range(0, 2) == 0) begin
          if (is_wr) sdram_rd_ack = 1'b1;
          else sdram_wr_ack = 1'b1;
        end
        tick();
        sdram_wr_ack = 1'b0;
        sdram_rd_ack = 1'b0;
        if (!burst_ok(is_wr, exp_addr)) held = 1'b0;
      end
      if (i == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("async_rst_rd_req", sdram_rd_req, 0);
        chk("async_rst_wr_req", sdram_wr_req, 0);
        chk("async_rst_rd_addr", sdram_rd_addr, RB);
        chk("async_rst_wr_addr", sdram_wr_addr, WB);
        chk("async_rst_busy", busy, 0);
        wr_n = 0;
        rd_n = 0;
        prio_wr = 1'b1;
        wr_fifo_num = '0;
        rd_en = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        return;
      end
      if (i == load_at) begin
        if (is_wr) wr_load = 1'b1;
        else rd_load = 1'b1;
      end
      if (i == drop_at) rd_en = 1'b0;
      if (is_wr) sdram_wr_ack = 1'b1;
      else sdram_rd_ack = 1'b1;
      tick();
      sdram_wr_ack = 1'b0;
      sdram_rd_ack = 1'b0;
      wr_load = 1'b0;
      rd_load = 1'b0;
      if (i < int'(BL) - 1 && !burst_ok(is_wr, exp_addr)) held = 1'b0;
    end
    chk("req_held_addr_stable", 32'(held), 1);
    chk("req_drop_after_last_ack", is_wr ? sdram_wr_req : sdram_rd_req, 0);
    if (is_wr) wr_n++;
    else rd_n++;
    chk(is_wr ? "wr_addr_after_burst" : "rd_addr_after_burst",
        is_wr ? sdram_wr_addr : sdram_rd_addr, is_wr ? exp_wr_addr() : exp_rd_addr());
  endtask

  // From idle with inputs set: one decision edge, then the expected burst (or none).
  task automatic go(input int load_at, input int rst_at, input int drop_at);
    int d;
    expected_dir(d);
    tick();
    if (d == 0) begin
      tick();
      chk("no_wr_req", sdram_wr_req, 0);
      chk("no_rd_req", sdram_rd_req, 0);
      chk("idle_busy", busy, 0);
    end else begin
      run_burst(d == 1, load_at, rst_at, drop_at);
    end
  endtask

  // Called right after the final ack of a burst during which a load was pulsed.
  task automatic check_flush(input bit is_wr);
    tick();
    chk("flush_rst_c1", is_wr ? fifo_wr_rst : fifo_rd_rst, 1);
    chk("flush_other_rst", is_wr ? fifo_rd_rst : fifo_wr_rst, 0);
    chk("flush_busy", busy, 1);
    chk("flush_no_req", 32'({sdram_wr_req, sdram_rd_req}), 0);
    tick();
    chk("flush_rst_c2", is_wr ? fifo_wr_rst : fifo_rd_rst, 1);
    tick();
    chk("flush_rst_end", 32'({fifo_wr_rst, fifo_rd_rst}), 0);
    chk("flush_exit_no_req", 32'({sdram_wr_req, sdram_rd_req}), 0);
    chk("flush_exit_busy", busy, 0);
    if (is_wr) wr_n = 0;
    else rd_n = 0;
    chk(is_wr ? "wr_addr_reload" : "rd_addr_reload",
        is_wr ? sdram_wr_addr : sdram_rd_addr, is_wr ? 32'(WB) : 32'(RB));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset values, checked before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_wr_req", sdram_wr_req, 0);
    chk("rst_rd_req", sdram_rd_req, 0);
    chk("rst_wr_addr", sdram_wr_addr, WB);
    chk("rst_rd_addr", sdram_rd_addr, RB);
    chk("rst_fifo_rsts", 32'({fifo_wr_rst, fifo_rd_rst}), 0);
    chk("rst_busy", busy, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Single write burst at exactly BURST_LEN words.
    wr_fifo_num = 10'd256;
    go(-1, -1, -1);
    wr_fifo_num = '0;
    tick();

    // Both pending: round-robin WR, RD, WR.
    wr_fifo_num = 10'd300;
    rd_en = 1'b1;
    rd_fifo_num = '0;
    go(-1, -1, -1);
    go(-1, -1, -1);
    go(-1, -1, -1);
    wr_fifo_num = '0;
    rd_en = 1'b0;
    tick();

    // Last write burst of the region wraps to base.
    wr_fifo_num = 10'd256;
    go(-1, -1, -1);
    chk("wr_wrap_to_base", sdram_wr_addr, WB);

    // wr_load mid-burst: burst completes, then flush, then restart from base.
    wr_fifo_num = 10'd300;
    go(100, -1, -1);
    check_flush(1'b1);
    go(-1, -1, -1);
    wr_fifo_num = '0;
    tick();

    // Reset in the middle of a read burst, then a clean read burst from base.
    rd_en = 1'b1;
    rd_fifo_num = 10'd100;
    go(-1, 50, -1);
    rd_en = 1'b1;
    go(-1, -1, -1);
    rd_en = 1'b0;
    tick();

    // Read threshold boundary; stray acks while idle are ignored.
    rd_en = 1'b1;
    rd_fifo_num = 10'd600;
    for (int k = 0; k < 3; k++) begin
      sdram_wr_ack = 1'b1;
      sdram_rd_ack = 1'b1;
      tick();
      sdram_wr_ack = 1'b0;
      sdram_rd_ack = 1'b0;
      chk("rd_above_thresh_no_req", sdram_rd_req, 0);
    end
    rd_fifo_num = 10'd512;
    tick();
    tick();
    chk("rd_at_thresh_no_req", sdram_rd_req, 0);
    rd_fifo_num = 10'd511;
    go(200, -1, -1);
    check_flush(1'b0);
    go(-1, -1, 128);
    rd_en = 1'b0;
    rd_fifo_num = '0;
    tick();

    // Randomised fill levels against the model.
    for (int it = 0; it < 8; it++) begin
      wr_fifo_num = 10'($urandom_range(0, 400));
      rd_en = 1'($urandom_range(0, 1));
      rd_fifo_num = 10'($urandom_range(0, 700));
      go(-1, -1, -1);
      wr_fifo_num = '0;
      rd_en = 1'b0;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
